// File: rtl/packet_serializer_pkg.sv
// ============================================================================
// Module   : packet_serializer_pkg
// Purpose  : Shared frame geometry and serializer state encoding.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package packet_serializer_pkg;

  localparam int PACKET_WIDTH    = 4;
  localparam int INDEX_WIDTH     = 2;
  localparam int PREAMBLE_LENGTH = 8;
  localparam logic [PREAMBLE_LENGTH-1:0] PREAMBLE = 8'hA5;

  // Preamble occupies the frame LSBs so it is the first thing on air.
  localparam int FRAME_BITS = PACKET_WIDTH * (8 + INDEX_WIDTH) + PREAMBLE_LENGTH;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GUARD = 2'd2
  } ser_state_t;

endpackage

`default_nettype wire

// File: rtl/packet_serializer_symbol_timer.sv
// ============================================================================
// Module   : packet_serializer_symbol_timer
// Purpose  : Symbol-period cycle counter; strobes on the first and last cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module packet_serializer_symbol_timer #(
  parameter int SYMBOL_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_run,
  output logic o_strobe,
  output logic o_last
);

  localparam int c_cnt_w = $clog2(SYMBOL_CYCLES) + 1;
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(SYMBOL_CYCLES - 1);

  logic [c_cnt_w-1:0] r_cyc_cnt;

  // Held at zero while idle so a new run always starts on a symbol boundary.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cyc_cnt <= '0;
    end else if (!i_run || (r_cyc_cnt == c_last)) begin
      r_cyc_cnt <= '0;
    end else begin
      r_cyc_cnt <= r_cyc_cnt + 1'b1;
    end
  end

  assign o_strobe = i_run && (r_cyc_cnt == '0);
  assign o_last   = i_run && (r_cyc_cnt == c_last);

endmodule

`default_nettype wire

// File: rtl/packet_serializer.sv
// ============================================================================
// Module   : packet_serializer
// Purpose  : Captures a sorted frame and shifts it out LSB first, one bit per
//            symbol period. Optional trailing guard: SERIALIZER_GUARD_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module packet_serializer
  import packet_serializer_pkg::*;
#(
  parameter int SYMBOL_CYCLES = 4
`ifdef SERIALIZER_GUARD_EN
  ,
  parameter int GUARD_SYMBOLS = 2
`endif
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_load,
  input  logic [FRAME_BITS-1:0] i_frame_in,
  output logic                  o_bit_out,
  output logic                  o_bit_valid,
  output logic                  o_symbol_strobe,
  output logic                  o_busy,
  output logic                  o_frame_done,
  output logic [7:0]            o_dropped_count
);

  localparam int c_bit_w = $clog2(FRAME_BITS);
  localparam logic [c_bit_w-1:0] c_last_bit = c_bit_w'(FRAME_BITS - 1);

  ser_state_t            r_state;
  ser_state_t            w_next_state;
  logic [FRAME_BITS-1:0] r_shreg;
  logic [c_bit_w-1:0]    r_bit_cnt;
  logic                  r_frame_done;
  logic [7:0]            r_dropped;
  logic                  w_run;
  logic                  w_strobe;
  logic                  w_last;
  logic                  w_frame_end;
  logic                  w_done;

  assign w_run       = (r_state != IDLE);
  assign w_frame_end = (r_state == SHIFT) && w_last && (r_bit_cnt == c_last_bit);

  packet_serializer_symbol_timer #(
    .SYMBOL_CYCLES (SYMBOL_CYCLES)
  ) u_symbol_timer (
    .clk      (clk),
    .reset    (reset),
    .i_run    (w_run),
    .o_strobe (w_strobe),
    .o_last   (w_last)
  );

`ifdef SERIALIZER_GUARD_EN
  localparam int c_guard_w = $clog2(GUARD_SYMBOLS) + 1;
  localparam logic [c_guard_w-1:0] c_guard_last = c_guard_w'(GUARD_SYMBOLS - 1);

  logic [c_guard_w-1:0] r_guard_cnt;
  logic                 w_guard_end;

  assign w_guard_end = (r_state == GUARD) && w_last && (r_guard_cnt == c_guard_last);

  always_ff @(posedge clk) begin
    if (reset || (r_state != GUARD)) begin
      r_guard_cnt <= '0;
    end else if (w_last) begin
      r_guard_cnt <= w_guard_end ? '0 : r_guard_cnt + 1'b1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_done       = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_load) begin
          w_next_state = SHIFT;
        end
      end
      SHIFT: begin
        if (w_frame_end) begin
`ifdef SERIALIZER_GUARD_EN
          w_next_state = GUARD;
`else
          w_next_state = IDLE;
          w_done       = 1'b1;
`endif
        end
      end
`ifdef SERIALIZER_GUARD_EN
      GUARD: begin
        if (w_guard_end) begin
          w_next_state = IDLE;
          w_done       = 1'b1;
        end
      end
`endif
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_shreg      <= '0;
      r_bit_cnt    <= '0;
      r_frame_done <= 1'b0;
      r_dropped    <= '0;
    end else begin
      r_frame_done <= w_done;
      if ((r_state == IDLE) && i_load) begin
        r_shreg   <= i_frame_in;
        r_bit_cnt <= '0;
      end else if ((r_state == SHIFT) && w_last) begin
        r_shreg   <= r_shreg >> 1;
        r_bit_cnt <= w_frame_end ? '0 : r_bit_cnt + 1'b1;
      end
      // Loads arriving mid-frame are discarded, only counted.
      if (w_run && i_load && (r_dropped != 8'hFF)) begin
        r_dropped <= r_dropped + 8'd1;
      end
    end
  end

  assign o_bit_out       = (r_state == SHIFT) && r_shreg[0];
  assign o_bit_valid     = (r_state == SHIFT);
  assign o_symbol_strobe = w_strobe;
  assign o_busy          = w_run;
  assign o_frame_done    = r_frame_done;
  assign o_dropped_count = r_dropped;

endmodule

`default_nettype wire

// File: tb/tb_packet_serializer.sv
// ============================================================================
// Module   : tb_packet_serializer
// Purpose  : Self-checking bench; two instances (SYMBOL_CYCLES 4 and 1) against
//            a timeline reference model. Honours SERIALIZER_GUARD_EN.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_packet_serializer;
  import packet_serializer_pkg::*;

  localparam int NI = 2;
`ifdef SERIALIZER_GUARD_EN
  localparam int GUARD_SYM = 2;
`else
  localparam int GUARD_SYM = 0;
`endif

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  load;
  logic [FRAME_BITS-1:0] frame;
  logic [NI-1:0]         bo, bv, st, bz, fd;
  logic [7:0]            dc [NI];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  packet_serializer #(.SYMBOL_CYCLES(4)) u_dut0 (
    .clk(clk), .reset(reset), .i_load(load), .i_frame_in(frame),
    .o_bit_out(bo[0]), .o_bit_valid(bv[0]), .o_symbol_strobe(st[0]),
    .o_busy(bz[0]), .o_frame_done(fd[0]), .o_dropped_count(dc[0])
  );

  packet_serializer #(.SYMBOL_CYCLES(1)) u_dut1 (
    .clk(clk), .reset(reset), .i_load(load), .i_frame_in(frame),
    .o_bit_out(bo[1]), .o_bit_valid(bv[1]), .o_symbol_strobe(st[1]),
    .o_busy(bz[1]), .o_frame_done(fd[1]), .o_dropped_count(dc[1])
  );

  // Reference model: each instance is a timeline starting at t0; outputs follow
  // from the cycle offset k = n - t0 by plain arithmetic.
  int                    n = 0;
  bit                    act   [NI];
  int                    t0    [NI];
  logic [FRAME_BITS-1:0] mf    [NI];
  int                    mdrop [NI];
  bit                    mon_en = 1'b0;

  function automatic int sc_of(int i);
    return (i == 0) ? 4 : 1;
  endfunction

  function automatic int total_of(int i);
    return (FRAME_BITS + GUARD_SYM) * sc_of(i);
  endfunction

  function automatic bit model_busy(int i);
    int k;
    k = n - t0[i];
    return act[i] && (k >= 0) && (k < total_of(i));
  endfunction

  function automatic logic [12:0] expect_out(int i);
    int   k;
    logic ebo, ebv, est, ebz, efd;
    k   = n - t0[i];
    ebz = model_busy(i);
    ebv = act[i] && (k >= 0) && (k < FRAME_BITS * sc_of(i));
    ebo = ebv ? mf[i][k / sc_of(i)] : 1'b0;
    est = ebz && ((k % sc_of(i)) == 0);
    efd = act[i] && (k == total_of(i));
    return {ebo, ebv, est, ebz, efd, 8'(mdrop[i])};
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (reset) begin
        act[i]   = 1'b0;
        mdrop[i] = 0;
      end else if (load) begin
        if (!model_busy(i)) begin
          act[i] = 1'b1;
          t0[i]  = n + 1;
          mf[i]  = frame;
        end else if (mdrop[i] < 255) begin
          mdrop[i]++;
        end
      end
    end
    n++;
    if (reset) mon_en = 1'b1;
  end

  always @(negedge clk) begin
    if (mon_en) begin
      for (int i = 0; i < NI; i++) begin : mon
        logic [12:0] g_out, e_out;
        g_out = {bo[i], bv[i], st[i], bz[i], fd[i], dc[i]};
        e_out = expect_out(i);
        checks++;
        if (g_out !== e_out) begin
          failures++;
          $display("FAIL model_inst%0d cycle %0d: got %h expected %h (bo,bv,st,bz,fd,drop)",
                   i, n, g_out, e_out);
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, expv);
    end
  endtask

  task automatic wait_idle();
    int c;
    c = 0;
    while ((bz !== 2'b00) && (c < 1000)) begin
      tick();
      c++;
    end
    chk("wait_idle_in_time", 32'(c < 1000), 32'd1);
  endtask

  function automatic logic [FRAME_BITS-1:0] rand_frame();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[FRAME_BITS-1:0];
  endfunction

  // Directed checkpoints for the A5 frame on the 4-cycle instance.
  typedef struct packed {
    logic [15:0] off;
    logic [4:0]  exp_bits;   // {bit_out, strobe, valid, busy, done}
  } vec_t;

  vec_t tbl [24];
  int   ntbl = 0;

  task automatic add_vec(input int off, input logic [4:0] b);
    tbl[ntbl] = '{16'(off), b};
    ntbl++;
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int idx, nstb, d0, ones, busyc, c, ndone;
    logic [FRAME_BITS-1:0] f;

    add_vec(1,   5'b11110); add_vec(2,   5'b10110); add_vec(4,   5'b10110);
    add_vec(5,   5'b01110); add_vec(9,   5'b11110); add_vec(13,  5'b01110);
    add_vec(17,  5'b01110); add_vec(21,  5'b11110); add_vec(25,  5'b01110);
    add_vec(29,  5'b11110); add_vec(30,  5'b10110); add_vec(33,  5'b01110);
    add_vec(189, 5'b01110); add_vec(192, 5'b00110);
`ifdef SERIALIZER_GUARD_EN
    add_vec(193, 5'b01010); add_vec(194, 5'b00010); add_vec(197, 5'b01010);
    add_vec(200, 5'b00010); add_vec(201, 5'b00001); add_vec(202, 5'b00000);
`else
    add_vec(193, 5'b00001); add_vec(194, 5'b00000);
`endif

    reset = 1'b1;
    load  = 1'b0;
    frame = '0;
    repeat (3) tick();
    chk("reset_state_inst0", {bo[0], bv[0], st[0], bz[0], fd[0], dc[0]}, 32'd0);
    chk("reset_state_inst1", {bo[1], bv[1], st[1], bz[1], fd[1], dc[1]}, 32'd0);
    reset = 1'b0;
    tick();

    // A5 frame: bit sequence, strobe count, frame_done latency
    frame = 48'h0000_0000_00A5;
    load  = 1'b1;
    tick();
    load  = 1'b0;
    idx   = 0;
    nstb  = 0;
    for (int off = 1; off <= int'(tbl[ntbl-1].off); off++) begin
      if (off <= FRAME_BITS * 4) nstb += int'(st[0]);
      if ((idx < ntbl) && (int'(tbl[idx].off) == off)) begin
        chk($sformatf("a5_off%0d", off), {bo[0], st[0], bv[0], bz[0], fd[0]}, tbl[idx].exp_bits);
        idx++;
      end
      tick();
    end
    chk("a5_strobe_count", nstb, 48);

    // Load 10 cycles into a frame is dropped
    wait_idle();
    frame = rand_frame();
    load  = 1'b1;
    tick();
    load  = 1'b0;
    repeat (9) tick();
    frame = rand_frame();
    load  = 1'b1;
    tick();
    load  = 1'b0;
    chk("drop_one_inst0", dc[0], 32'd1);
    chk("drop_one_inst1", dc[1], 32'd1);

    // Sustained loads saturate the drop counter
    wait_idle();
    for (int i = 0; i < 300; i++) begin
      load  = 1'b1;
      frame = rand_frame();
      tick();
    end
    load = 1'b0;
    chk("drop_sat_inst0", dc[0], 32'd255);
    chk("drop_sat_inst1", dc[1], 32'd255);

    // Load on the frame_done cycle gives a zero-gap follow-on frame
    wait_idle();
    frame = rand_frame();
    load  = 1'b1;
    tick();
    load  = 1'b0;
    c = 0;
    while ((fd[0] !== 1'b1) && (c < 400)) begin
      tick();
      c++;
    end
    chk("b2b_done_seen", 32'(c < 400), 32'd1);
    chk("b2b_gap_valid_low", bv[0], 32'd0);
    frame = rand_frame();
    load  = 1'b1;
    tick();
    load  = 1'b0;
    chk("b2b_first_symbol", {st[0], bv[0], bz[0]}, 32'b111);

    // Reset at bit 20 aborts silently; a fresh frame restarts from bit 0
    wait_idle();
    frame = rand_frame();
    load  = 1'b1;
    tick();
    load  = 1'b0;
    repeat (80) tick();
    chk("rst_mid_busy", bz[0], 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_mid_outputs", {bo[0], bv[0], st[0], bz[0], fd[0], dc[0]}, 32'd0);
    ndone = 0;
    for (int i = 0; i < 200; i++) begin
      ndone += int'(fd[0]);
      tick();
    end
    chk("rst_mid_no_done", ndone, 32'd0);
    f     = rand_frame();
    frame = f;
    load  = 1'b1;
    tick();
    load  = 1'b0;
    chk("rst_restart_bit0", {bo[0], st[0], bv[0]}, {f[0], 2'b11});

    // SYMBOL_CYCLES=1 with an all-ones frame
    wait_idle();
    frame = '1;
    load  = 1'b1;
    tick();
    load  = 1'b0;
    ones  = 0;
    busyc = 0;
    for (int i = 0; i < 60; i++) begin
      if (bo[1] && st[1]) ones++;
      if (bz[1]) busyc++;
      tick();
    end
    chk("sc1_ones_strobes", ones, 32'd48);
    chk("sc1_busy_cycles", busyc, 32'(48 + GUARD_SYM));

`ifdef SERIALIZER_GUARD_EN
    // Load inside the guard window is dropped
    wait_idle();
    frame = rand_frame();
    load  = 1'b1;
    tick();
    load  = 1'b0;
    repeat (194) tick();
    chk("guard_window_state", {bv[0], bz[0]}, 32'b01);
    d0    = int'(dc[0]);
    load  = 1'b1;
    tick();
    load  = 1'b0;
    chk("guard_load_dropped", dc[0], 32'(d0 + 1));
`else
    d0 = 0;
`endif

    // Randomized traffic against the model, with occasional resets
    wait_idle();
    for (int i = 0; i < 4000; i++) begin
      load  = ($urandom_range(0, 39) == 0);
      frame = rand_frame();
      reset = ($urandom_range(0, 1499) == 0);
      tick();
    end
    load  = 1'b0;
    reset = 1'b0;
    wait_idle();
    repeat (2) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/packet_serializer.md
Name: packet_serializer

Overview:
- Downstream of the transmit sorter stage.
- Captures the sorted frame (indices, data, preamble) on the sorter's done pulse.
- Shifts the frame out one bit per symbol period, LSB first, so the preamble leaves first.
- Feeds the BPSK modulator with a serial bit, a symbol strobe and a busy flag; counts frames dropped because they arrived while busy.

Parameters:
- PACKET_WIDTH, 4, bytes per packet (shared package value).
- INDEX_WIDTH, 2, bits per sort index (shared package value).
- PREAMBLE_LENGTH, 8, preamble bits at the frame LSBs (shared package value).
- SYMBOL_CYCLES, 4, clk cycles per transmitted bit; must be >= 1.
- GUARD_SYMBOLS, 2, symbol periods of trailing guard; used only with SERIALIZER_GUARD_EN.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- load  in  1  single-cycle pulse; frame_in valid this cycle (sorter done)
- frame_in  in  FRAME_BITS  sorted frame, bit 0 transmitted first
- bit_out  out  1  current serial bit
- bit_valid  out  1  high while bit_out carries a frame bit
- symbol_strobe  out  1  one-cycle pulse on the first cycle of each frame bit
- busy  out  1  high from the cycle after an accepted load until return to IDLE
- frame_done  out  1  one-cycle pulse on the cycle the block returns to IDLE
- dropped_count  out  8  saturating count of loads ignored while busy

Behaviour:
- FRAME_BITS = PACKET_WIDTH*(8+INDEX_WIDTH)+PREAMBLE_LENGTH; default value 48.
- Reset state, all synchronous to clk:
  - state IDLE.
  - shift register, bit counter and cycle counter cleared.
  - bit_out=0, bit_valid=0, symbol_strobe=0, busy=0, frame_done=0, dropped_count=0.
- Reset asserted mid-frame aborts the frame immediately: no frame_done, dropped_count cleared.
- IDLE:
  - load=1: capture frame_in into the shift register, bit_cnt=0, cyc_cnt=0, go to SHIFT.
  - Latency: the first bit appears on bit_out the cycle after load, with symbol_strobe=1, bit_valid=1 and busy=1.
- SHIFT:
  - bit_out = shreg[0].
  - cyc_cnt counts 0..SYMBOL_CYCLES-1.
  - symbol_strobe is high when cyc_cnt==0.
  - When cyc_cnt==SYMBOL_CYCLES-1: shift right by 1, bit_cnt++, cyc_cnt=0.
  - When bit_cnt==FRAME_BITS-1 and cyc_cnt==SYMBOL_CYCLES-1: go to GUARD if enabled, else IDLE.
  - Frame occupancy is FRAME_BITS*SYMBOL_CYCLES cycles of bit_valid.
- Return to IDLE: frame_done pulses for one cycle; busy and bit_valid drop in that same cycle; bit_out returns to 0.
- Load while busy (SHIFT or GUARD):
  - frame ignored, shift register untouched.
  - dropped_count increments, saturating at 255.
- Load on the frame_done cycle (state already IDLE): accepted, giving back-to-back frames with zero gap.
- SYMBOL_CYCLES=1: symbol_strobe stays high every frame cycle.
- Counter widths: bit_cnt is $clog2(FRAME_BITS) bits, cyc_cnt is $clog2(SYMBOL_CYCLES)+1 bits; no wrap inside a frame.

Optional Feature:
- Macro: SERIALIZER_GUARD_EN.
- Defined:
  - After the last bit, state GUARD holds bit_out=0, bit_valid=0, busy=1 for GUARD_SYMBOLS*SYMBOL_CYCLES cycles.
  - symbol_strobe still pulses each guard symbol, keeping the modulator's phase timing continuous.
  - Loads during GUARD are dropped and counted.
  - frame_done fires on leaving GUARD.
- Undefined: GUARD state and its counter are absent; the block goes SHIFT -> IDLE directly.

Decomposition:
- Shared package (existing parameters header) holds:
  - PACKET_WIDTH, INDEX_WIDTH, PREAMBLE_LENGTH, PREAMBLE.
  - FRAME_BITS as a localparam.
  - State enum ser_state_t {IDLE, SHIFT, GUARD}.
- One natural sub-module: symbol_timer.
  - Owns cyc_cnt and produces the symbol_strobe/last_cycle pulses.
  - Inputs: clk, reset, run.
  - Reusable by the receiver's bit sampler.

Test Plan:
- Reset, then load with frame_in=48'h0000_0000_00A5, SYMBOL_CYCLES=4:
  - bit_out sequence per symbol is 1,0,1,0,0,1,0,1 then 40 zeros.
  - 48 strobes.
  - frame_done exactly 193 cycles after load.
- Load, then second load 10 cycles later -> second frame ignored, dropped_count=1, transmitted bits unchanged. Then force 300 overlapping loads -> dropped_count saturates at 255.
- Load asserted on the frame_done cycle -> next frame's first strobe the following cycle; bit_valid low for exactly that one cycle.
- Reset asserted at bit 20 -> next cycle all outputs 0, no frame_done. A new load afterwards serializes from bit 0.
- SYMBOL_CYCLES=1 with frame_in all ones -> bit_out=1 and symbol_strobe=1 for 48 consecutive cycles, busy for 48 cycles.
- With SERIALIZER_GUARD_EN and GUARD_SYMBOLS=2:
  - after the last bit, 8 cycles with busy=1, bit_valid=0, strobes on cycles 0 and 4.
  - frame_done follows; a load in the guard window is dropped.
